// File: rtl/memory_control_system_if.sv
`default_nettype none
// ============================================================================
//  Module      : memory_control_system_if
//  Description : Execute-stage to RAM bus bundle for the memory controller.
//  Revision    : 1.0  initial release
// ============================================================================
interface memory_control_system_if;
    logic [3:0]  opcode;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] ram_data_in;
    logic [7:0]  pc;
    logic [31:0] alu_result;
    logic        rw;
    logic [15:0] addr_bus;
    logic [31:0] ram_data_out;
    logic [31:0] wb_data;
    logic        wb_en;

    modport master (
        output opcode, src1, src2, ram_data_in, pc, alu_result,
        input  rw, addr_bus, ram_data_out, wb_data, wb_en
    );

    modport slave (
        input  opcode, src1, src2, ram_data_in, pc, alu_result,
        output rw, addr_bus, ram_data_out, wb_data, wb_en
    );
endinterface
`default_nettype wire

// File: rtl/memory_control_system.sv
`default_nettype none
// ============================================================================
//  Module      : memory_control_system
//  Description : Two-stage memory-access controller (address phase, then
//                write-back data phase) between execute stage and RAM.
//  Revision    : 1.0  initial release
// ============================================================================
module memory_control_system #(
    parameter logic [3:0] OP_LDR = 4'b1000,
    parameter logic [3:0] OP_STR = 4'b1001
) (
    input  wire logic               clk,
    input  wire logic               rst,
    memory_control_system_if.slave  bus
);

    logic        r_valid;
    logic [3:0]  r_op;
    logic [31:0] r_alu;

    // Upper operand bits never reach the 16-bit address bus.
    logic w_unused_src2_hi;
    assign w_unused_src2_hi = &{1'b0, bus.src2[31:16]};

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.rw           <= 1'b0;
            bus.addr_bus     <= 16'h0000;
            bus.ram_data_out <= 32'h0;
            bus.wb_data      <= 32'h0;
            bus.wb_en        <= 1'b0;
            r_valid          <= 1'b0;
            r_op             <= 4'h0;
            r_alu            <= 32'h0;
        end else begin
            // Address phase: unknown opcodes fall to the fetch case.
            case (bus.opcode)
                OP_STR: begin
                    bus.rw           <= 1'b1;
                    bus.addr_bus     <= bus.src2[15:0];
                    bus.ram_data_out <= bus.src1;
                end
                OP_LDR: begin
                    bus.rw           <= 1'b0;
                    bus.addr_bus     <= bus.src2[15:0];
                    bus.ram_data_out <= 32'h0;
                end
                default: begin
                    bus.rw           <= 1'b0;
                    bus.addr_bus     <= {8'h00, bus.pc};
                    bus.ram_data_out <= 32'h0;
                end
            endcase
            r_op    <= bus.opcode;
            r_alu   <= bus.alu_result;
            r_valid <= 1'b1;

            // Data phase: RAM read data arrives while stage-1 address is driven.
            bus.wb_data <= (r_op == OP_LDR) ? bus.ram_data_in : r_alu;
            bus.wb_en   <= r_valid && (r_op != OP_STR);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_memory_control_system.sv
`default_nettype none
// ============================================================================
//  Module      : tb_memory_control_system
//  Description : Self-checking bench with a transaction-queue reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_memory_control_system;

    localparam logic [3:0] OP_LDR   = 4'b1000;
    localparam logic [3:0] OP_STR   = 4'b1001;
    localparam logic [3:0] OP_FETCH = 4'b1010;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] alu;
    } txn_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    memory_control_system_if bus ();

    memory_control_system dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    txn_t        pending[$];
    logic        e_rw;
    logic [15:0] e_addr;
    logic [31:0] e_dout;
    logic [31:0] e_wb;
    logic        e_en;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] s1, input logic [31:0] s2,
                         input logic [7:0] p, input logic [31:0] alu, input logic [31:0] rin);
        bus.opcode      = op;
        bus.src1        = s1;
        bus.src2        = s2;
        bus.pc          = p;
        bus.alu_result  = alu;
        bus.ram_data_in = rin;
    endtask

    // One clock: update the model from values seen at the edge, then compare.
    task automatic step();
        txn_t t;
        @(posedge clk);
        if (rst) begin
            pending.delete();
            e_rw = 1'b0; e_addr = 16'h0; e_dout = 32'h0; e_wb = 32'h0; e_en = 1'b0;
        end else begin
            if (pending.size() > 0) begin
                t    = pending.pop_front();
                e_wb = (t.op == OP_LDR) ? bus.ram_data_in : t.alu;
                e_en = (t.op != OP_STR);
            end else begin
                e_wb = 32'h0;
                e_en = 1'b0;
            end
            e_rw   = (bus.opcode == OP_STR);
            e_addr = (bus.opcode == OP_STR || bus.opcode == OP_LDR) ? bus.src2[15:0]
                                                                      : {8'h00, bus.pc};
            e_dout = (bus.opcode == OP_STR) ? bus.src1 : 32'h0;
            t.op  = bus.opcode;
            t.alu = bus.alu_result;
            pending.push_back(t);
        end
        #1;
        check("rw",           {31'h0, bus.rw},    {31'h0, e_rw});
        check("addr_bus",     {16'h0, bus.addr_bus}, {16'h0, e_addr});
        check("ram_data_out", bus.ram_data_out,   e_dout);
        check("wb_data",      bus.wb_data,        e_wb);
        check("wb_en",        {31'h0, bus.wb_en}, {31'h0, e_en});
    endtask

    initial begin
        logic [3:0] rop;
        rst = 1'b1;
        drive(4'h9, 32'hDEAD_BEEF, 32'h1234_5678, 8'hAB, 32'hCAFE_F00D, 32'h5555_AAAA);
        step();
        step();
        check("reset_addr", {16'h0, bus.addr_bus}, 32'h0);
        rst = 1'b0;
        drive(OP_FETCH, 32'h3, 32'h21, 8'h00, 32'h2, 32'h8);
        step();
        check("post_reset_wb_en", {31'h0, bus.wb_en}, 32'h0);
        step();
        check("fetch_wb_data", bus.wb_data, 32'h0000_0002);
        check("fetch_wb_en", {31'h0, bus.wb_en}, 32'h1);

        drive(OP_FETCH, 32'h3, 32'h21, 8'h5A, 32'h2, 32'h8);
        step();
        check("fetch_pc_addr", {16'h0, bus.addr_bus}, 32'h0000_005A);
        step();

        drive(OP_STR, 32'hC, 32'h9, 8'h00, 32'h2, 32'h0);
        step();
        check("str_rw", {31'h0, bus.rw}, 32'h1);
        check("str_dout", bus.ram_data_out, 32'h0000_000C);
        drive(OP_STR, 32'h30, 32'h3, 8'h00, 32'h2, 32'h0);
        step();
        check("str_wb_en", {31'h0, bus.wb_en}, 32'h0);
        check("str2_addr", {16'h0, bus.addr_bus}, 32'h0000_0003);

        drive(OP_LDR, 32'h18, 32'h5, 8'h00, 32'h2, 32'h78);
        step();
        check("ldr_addr", {16'h0, bus.addr_bus}, 32'h0000_0005);
        step();
        check("ldr_wb_data", bus.wb_data, 32'h0000_0078);

        // Back-to-back mix with no bubbles.
        drive(OP_FETCH, 32'h1, 32'h2, 8'h10, 32'h11, 32'h0);   step();
        drive(OP_STR,   32'h44, 32'h40, 8'h11, 32'h22, 32'h0); step();
        drive(OP_LDR,   32'h0, 32'h40, 8'h12, 32'h33, 32'h99); step();
        drive(OP_STR,   32'h55, 32'h41, 8'h13, 32'h44, 32'hABC); step();
        drive(OP_FETCH, 32'h0, 32'h0, 8'h14, 32'h66, 32'h77); step();
        step();

        // High address bits ignored, then reset while the load sits in stage 1.
        drive(OP_LDR, 32'h0, 32'hFFFF_1234, 8'h00, 32'h2, 32'h1);
        step();
        check("ldr_hi_addr", {16'h0, bus.addr_bus}, 32'h0000_1234);
        rst = 1'b1;
        drive(OP_STR, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'hFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        step();
        rst = 1'b0;
        drive(OP_FETCH, 32'h0, 32'h0, 8'h01, 32'h7, 32'h0);
        step();
        check("mid_reset_no_wb", {31'h0, bus.wb_en}, 32'h0);

        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0: rop = OP_LDR;
                1: rop = OP_STR;
                2: rop = OP_FETCH;
                default: rop = 4'($urandom);
            endcase
            rst = ($urandom_range(0, 31) == 0);
            drive(rop, $urandom, $urandom, 8'($urandom), $urandom, $urandom);
            step();
        end
        rst = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
